hwpe_ctrl_context_sched: RTL
============================

Name: hwpe_ctrl_context_sched

Overview:
Job-context scheduler for the HWPE control register file. It arbitrates the offload lock between cores (acquire/test-and-set, then trigger) and tracks occupancy of the N_CONTEXT job slots as a ring. It sequences the engine, issuing one start per committed job and retiring jobs on engine done. It produces the pointer/running context, full, critical and done flags that the register file consumes.

Parameters:
N_CONTEXT, 2, number of job contexts; range 1..4, not required to be a power of 2.
N_CORES, 8, number of requesters; ID width ID_W = max(1,$clog2(N_CORES)).
LOCK_TIMEOUT, 256, cycles; used only with the optional feature.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
acquire_i  in  1  test-and-set request, single-cycle strobe
acquire_id_i  in  ID_W  requester ID for acquire
trigger_i  in  1  commit request, single-cycle strobe
trigger_id_i  in  ID_W  requester ID for trigger
engine_done_i  in  1  engine finished current job, single-cycle pulse
acq_valid_o  out  1  acquire response valid, one cycle
acq_resp_o  out  2  0=granted, 1=all contexts busy, 2=another PE offloading
start_o  out  1  engine start pulse
true_done_o  out  1  job retired pulse
evt_o  out  N_CORES  one-hot done event to the job owner
pointer_context_o  out  max(1,$clog2(N_CONTEXT))  next slot to fill
running_context_o  out  max(1,$clog2(N_CONTEXT))  slot being or next to be executed
full_context_o  out  1  all slots occupied
is_critical_o  out  1  offload lock held
busy_o  out  1  any slot occupied
err_o  out  1  sticky: trigger rejected

Behaviour:
- Reset/clear: all outputs 0. Pointers 0, cnt 0, lock free, scheduler IDLE. clear_i overrides every other input in that cycle. A job in RUN is dropped with no done/evt.
- State: cnt in 0..N_CONTEXT counts occupied slots, including the running one. ptr and run wrap explicitly from N_CONTEXT-1 to 0. Lock state is a bit plus owner[ID_W]. owner_mem[N_CONTEXT] stores the ID of each committed job.
- Acquire is evaluated against the pre-cycle registered state. The response is registered: acq_valid_o and acq_resp_o appear 1 cycle after acquire_i.
  - Locked, id != owner -> resp 2.
  - Locked, id == owner -> resp 0; no state change.
  - Unlocked, cnt==N_CONTEXT -> resp 1.
  - Otherwise -> resp 0; lock=1 and owner=id on the next edge.
- Trigger is accepted only if the lock is held and trigger_id_i==owner.
  - Accepted: owner_mem[ptr]=id, ptr++, cnt++, lock released.
  - Otherwise ignored, and err_o is set until reset/clear.
  - Acquire and trigger in the same cycle: the acquire sees the lock still held, so a different ID gets resp 2. The trigger is still processed normally.
- Scheduler FSM:
  - IDLE -> START when cnt > 0.
  - START: start_o=1 for exactly one cycle; running_context_o is stable; go to RUN.
  - RUN: on engine_done_i, pulse true_done_o and evt_o[owner_mem[run]] for one cycle (registered, next cycle); run++; cnt--; go to IDLE.
  - engine_done_i in IDLE or START is ignored.
  - Consecutive jobs: start is at least 2 cycles after the previous done.
- Accepted trigger and retire in the same cycle: net cnt unchanged; both pointers advance.
- Flags:
  - full_context_o = (cnt==N_CONTEXT).
  - busy_o = (cnt!=0).
  - is_critical_o = lock.
  - All flags are registered-state derived, so there are no combinational paths from inputs.
- The counter never overflows: a trigger is only accepted after a granted acquire, and grants require cnt<N_CONTEXT. An owner re-acquire cannot grow cnt.

Optional Feature:
Macro HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN.
- Defined:
  - A counter starts at lock grant and increments each cycle while locked.
  - At LOCK_TIMEOUT cycles without a trigger, the lock is forcibly released and err_o is set.
  - A later trigger from the old owner is rejected.
- Undefined: the lock is held indefinitely until the owner triggers. No counter logic is present.

Test Plan:
1. N_CONTEXT=2: acquire id3 -> next cycle resp 0, is_critical_o=1. Trigger id3 -> pointer_context_o=1, is_critical_o=0, start_o pulses with running_context_o=0.
2. Lock held by id3: acquire id5 -> resp 2. Acquire id3 -> resp 0. Trigger id5 -> ignored, err_o=1.
3. Commit 2 jobs without engine_done -> full_context_o=1; acquire id1 -> resp 1. Assert engine_done_i -> true_done_o, evt_o=8'b0000_1000 for the owner id3, full_context_o=0.
4. N_CONTEXT=3: run 5 jobs back-to-back from ids 0..4 -> pointer/running contexts wrap 2->0. evt_o bits 0..4 fire in order; start_o spacing >=2 cycles after each done.
5. Trigger accepted in the same cycle as engine_done_i with cnt=1 -> cnt stays 1; next start uses running_context_o=1.
6. clear_i during RUN -> all outputs 0 next cycle. A subsequent engine_done_i produces no true_done_o. With the macro defined and LOCK_TIMEOUT=4: acquire then no trigger -> is_critical_o drops after 4 cycles and err_o=1.

Source files
------------

// File: rtl/hwpe_ctrl_context_sched.sv
// hwpe_ctrl_context_sched: offload-lock arbitration between cores, ring-ordered
// occupancy of the N_CONTEXT job slots, and engine start/retire sequencing.
// Every flag seen by the register file comes from registered state.
// Optional build macro HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN: force-release a lock
// that has been held for LOCK_TIMEOUT cycles without a trigger, and flag err_o.
module hwpe_ctrl_context_sched #(
  parameter int  N_CONTEXT    = 2,
  parameter int  N_CORES      = 8,
  parameter int  LOCK_TIMEOUT = 256,
  localparam int ID_W         = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  localparam int CTX_W        = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               acquire_i,
  input  logic [ID_W-1:0]    acquire_id_i,
  input  logic               trigger_i,
  input  logic [ID_W-1:0]    trigger_id_i,
  input  logic               engine_done_i,
  output logic               acq_valid_o,
  output logic [1:0]         acq_resp_o,
  output logic               start_o,
  output logic               true_done_o,
  output logic [N_CORES-1:0] evt_o,
  output logic [CTX_W-1:0]   pointer_context_o,
  output logic [CTX_W-1:0]   running_context_o,
  output logic               full_context_o,
  output logic               is_critical_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int               CNT_W    = $clog2(N_CONTEXT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_CONTEXT);
  localparam logic [CTX_W-1:0] CTX_LAST = CTX_W'(N_CONTEXT - 1);

  localparam logic [1:0] RESP_GRANT = 2'd0;
  localparam logic [1:0] RESP_FULL  = 2'd1;
  localparam logic [1:0] RESP_OTHER = 2'd2;

  // Reject out-of-range configurations at elaboration.
  if (N_CONTEXT < 1 || N_CONTEXT > 4) begin : g_bad_n_context
    $error("N_CONTEXT must be in 1..4");
  end
  if (LOCK_TIMEOUT < 1) begin : g_bad_lock_timeout
    $error("LOCK_TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, START, RUN} state_e;

  state_e                 state_q, state_d;
  logic                   lock_q;
  logic [ID_W-1:0]        owner_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CTX_W-1:0]       ptr_q, run_q;
  logic [ID_W-1:0]        owner_mem [N_CONTEXT];
  logic                   acq_valid_q;
  logic [1:0]             acq_resp_q, acq_resp_d;
  logic                   done_q;
  logic [N_CORES-1:0]     evt_q;
  logic                   err_q;

  logic grant, trig_ok, trig_bad, retire, timeout;

  // Acquire and trigger decisions use only the pre-cycle registered state.
  assign grant    = acquire_i && !lock_q && (cnt_q != CNT_FULL);
  assign trig_ok  = trigger_i && lock_q && (trigger_id_i == owner_q);
  assign trig_bad = trigger_i && !trig_ok;
  assign retire   = (state_q == RUN) && engine_done_i;

  // Acquire response: foreign lock beats full, the owner re-acquiring is granted.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    acq_resp_d = RESP_GRANT;
    if (lock_q) begin
      acq_resp_d = (acquire_id_i == owner_q) ? RESP_GRANT : RESP_OTHER;
    end else if (cnt_q == CNT_FULL) begin
      acq_resp_d = RESP_FULL;
    end
  end

`ifdef HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;

  // A trigger landing on the last allowed cycle still wins over the timeout.
  assign timeout = lock_q && !trig_ok && (tmo_q == TMO_W'(LOCK_TIMEOUT - 1));

  // Lock age: restarts on grant, advances every cycle the lock is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (clear_i || grant) begin
      tmo_q <= '0;
    end else if (lock_q) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Offload lock and its owner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (clear_i) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (grant) begin
      lock_q  <= 1'b1;
      owner_q <= acquire_id_i;
    end else if (trig_ok || timeout) begin
      lock_q  <= 1'b0;
    end
  end

  // Slot ring: fill pointer, run pointer and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      run_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      ptr_q <= '0;
      run_q <= '0;
      cnt_q <= '0;
    end else begin
      if (trig_ok) ptr_q <= (ptr_q == CTX_LAST) ? '0 : ptr_q + 1'b1;
      if (retire)  run_q <= (run_q == CTX_LAST) ? '0 : run_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(trig_ok) - CNT_W'(retire);
    end
  end

  // Owner of each committed job, read back when the job retires.
  always_ff @(posedge clk_i) begin
    // NOTE: storage needs no reset; a slot is only read after a trigger has written it.
    if (trig_ok && !clear_i) owner_mem[ptr_q] <= trigger_id_i;
  end

  // Scheduler state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (clear_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scheduler next state: one start per job, retire on engine done in RUN only.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cnt_q != '0) state_d = START;
      START:   state_d = RUN;
      RUN:     if (engine_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered response, retire pulses and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acq_valid_q <= 1'b0;
      acq_resp_q  <= RESP_GRANT;
      done_q      <= 1'b0;
      evt_q       <= '0;
      err_q       <= 1'b0;
    end else if (clear_i) begin
      acq_valid_q <= 1'b0;
      acq_resp_q  <= RESP_GRANT;
      done_q      <= 1'b0;
      evt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      acq_valid_q <= acquire_i;
      acq_resp_q  <= acquire_i ? acq_resp_d : RESP_GRANT;
      done_q      <= retire;
      evt_q       <= retire ? (N_CORES'(1) << owner_mem[run_q]) : '0;
      err_q       <= err_q | trig_bad | timeout;
    end
  end

  assign acq_valid_o       = acq_valid_q;
  assign acq_resp_o        = acq_resp_q;
  assign start_o           = (state_q == START);
  assign true_done_o       = done_q;
  assign evt_o             = evt_q;
  assign pointer_context_o = ptr_q;
  assign running_context_o = run_q;
  assign full_context_o    = (cnt_q == CNT_FULL);
  assign is_critical_o     = lock_q;
  assign busy_o            = (cnt_q != '0);
  assign err_o             = err_q;

endmodule
